tft_cursor_overlay: RTL and testbench

Parametrised cell-grid cursor and selection overlay for the TFT LCD pipeline of the chess SoC. It takes the panel timing counters (`HsyncCount`, `VsyncCount`, `DE`) and five active-low push buttons. It keeps a cursor position on a COLS x ROWS board with saturating moves, plus a select/confirm state machine. Each pixel is drawn as a cursor frame, a selected-cell fill, or black, as RGB565. Button inputs are synchronised and debounced inside the block; a completed from/to move is reported to software-facing logic as a one-cycle strobe.

---
 rtl/tft_cursor_overlay.sv | 140 ++++++++++++++
 tb/tb_tft_cursor_overlay.sv | 138 +++++++++++++
 2 files changed

// File: rtl/tft_cursor_overlay.sv
// tft_cursor_overlay: debounced cursor and selection overlay on a COLS x ROWS cell grid, drawn as RGB565.
module tft_cursor_overlay #(
   parameter int H_ORIGIN = 43,
   parameter int V_ORIGIN = 12,
   parameter int CELL_W = 60,
   parameter int CELL_H = 34,
   parameter int COLS = 8,
   parameter int ROWS = 8,
   parameter int BORDER = 2,
   parameter int DEBOUNCE = 65536,
   parameter logic [15:0] CURSOR_RGB = 16'hF81F,
   parameter logic [15:0] SELECT_RGB = 16'h07E0
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic [9:0]                HsyncCount,
   input  logic [9:0]                VsyncCount,
   input  logic                      DE,
   input  logic                      Move_Left,
   input  logic                      Move_Up,
   input  logic                      Move_Down,
   input  logic                      Move_Right,
   input  logic                      Select,
   output logic [4:0]                R,
   output logic [5:0]                G,
   output logic [4:0]                B,
   output logic [$clog2(COLS)-1:0]   cur_col,
   output logic [$clog2(ROWS)-1:0]   cur_row,
   output logic                      sel_valid,
   output logic [$clog2(COLS)-1:0]   sel_col,
   output logic [$clog2(ROWS)-1:0]   sel_row,
   output logic                      move_strobe
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam int DW = $clog2(DEBOUNCE);
   typedef enum logic {IDLE, HELD} state_t;
   logic [4:0] raw, press;
   assign raw = {Select, Move_Right, Move_Down, Move_Up, Move_Left};
   genvar i;
   for (i = 0; i < 5; i++) begin : g_btn
      logic s1, s2, lvl, p;
      logic [DW-1:0] cnt;
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            lvl <= 1'b1;
            cnt <= '0;
            p <= 1'b0;
         end else begin
            s1 <= raw[i];
            s2 <= s1;
            p <= 1'b0;
            if (s2 == lvl)
               cnt <= '0;
            else if (cnt == DW'(DEBOUNCE - 1)) begin
               lvl <= s2;
               cnt <= '0;
               p <= lvl;
            end else
               cnt <= cnt + 1'b1;
         end
      assign press[i] = p;
   end
   logic pl, pu, pd, pr, ps;
   assign {ps, pr, pd, pu, pl} = press;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         cur_col <= '0;
         cur_row <= '0;
      end else begin
         if (pl && !pr && cur_col != '0) cur_col <= cur_col - 1'b1;
         else if (pr && !pl && cur_col != CW'(COLS - 1)) cur_col <= cur_col + 1'b1;
         if (pu && !pd && cur_row != '0) cur_row <= cur_row - 1'b1;
         else if (pd && !pu && cur_row != RW'(ROWS - 1)) cur_row <= cur_row + 1'b1;
      end
   state_t state, state_n;
   logic strobe_n;
   logic [CW-1:0] sel_col_n;
   logic [RW-1:0] sel_row_n;
   // Uses the pre-move cursor: cur_* only changes at the same edge the FSM registers.
   always_comb begin
      state_n = state;
      strobe_n = 1'b0;
      sel_col_n = '0;
      sel_row_n = '0;
      if (state == IDLE) begin
         if (ps) begin
            state_n = HELD;
            sel_col_n = cur_col;
            sel_row_n = cur_row;
         end
      end else begin
         sel_col_n = sel_col;
         sel_row_n = sel_row;
         if (ps) begin
            state_n = IDLE;
            if (cur_col == sel_col && cur_row == sel_row) begin
               sel_col_n = '0;
               sel_row_n = '0;
            end else
               strobe_n = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         move_strobe <= 1'b0;
         sel_col <= '0;
         sel_row <= '0;
      end else begin
         state <= state_n;
         move_strobe <= strobe_n;
         sel_col <= sel_col_n;
         sel_row <= sel_row_n;
      end
   assign sel_valid = (state == HELD);
   logic [11:0] x, y, cx, cy, sx, sy;
   logic in_cur, in_ring, in_sel;
   logic [15:0] rgb, rgb_n;
   assign x = {2'b00, HsyncCount};
   assign y = {2'b00, VsyncCount};
   assign cx = 12'(H_ORIGIN) + 12'(cur_col) * 12'(CELL_W);
   assign cy = 12'(V_ORIGIN) + 12'(cur_row) * 12'(CELL_H);
   assign sx = 12'(H_ORIGIN) + 12'(sel_col) * 12'(CELL_W);
   assign sy = 12'(V_ORIGIN) + 12'(sel_row) * 12'(CELL_H);
   assign in_cur = x >= cx && x <= cx + 12'(CELL_W - 1) && y >= cy && y <= cy + 12'(CELL_H - 1);
   assign in_ring = in_cur && (x < cx + 12'(BORDER) || x > cx + 12'(CELL_W - 1 - BORDER) ||
                               y < cy + 12'(BORDER) || y > cy + 12'(CELL_H - 1 - BORDER));
   assign in_sel = sel_valid && x >= sx && x <= sx + 12'(CELL_W - 1) && y >= sy && y <= sy + 12'(CELL_H - 1);
   assign rgb_n = !DE ? 16'h0000 : in_ring ? CURSOR_RGB : in_sel ? SELECT_RGB : 16'h0000;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) rgb <= '0;
      else rgb <= rgb_n;
   assign R = rgb[15:11];
   assign G = rgb[10:5];
   assign B = rgb[4:0];
endmodule

// File: tb/tb_tft_cursor_overlay.sv
// tb_tft_cursor_overlay: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_tft_cursor_overlay;
   logic clk = 1'b0, rstn = 1'b0, de = 1'b0;
   logic [9:0] hs = '0, vs = '0;
   logic [4:0] btn = '1;
   logic [4:0] r, b;
   logic [5:0] g;
   logic [2:0] cur_col, cur_row, sel_col, sel_row;
   logic sel_valid, move_strobe;
   typedef struct {string nm; int k; int v;} exp_t;
   exp_t sb[$];
   int n_cmp = 0, n_fail = 0, n_strobe = 0;
   always #5 clk = ~clk;
   tft_cursor_overlay #(.DEBOUNCE(4)) dut (
      .clk(clk), .rstn(rstn), .HsyncCount(hs), .VsyncCount(vs), .DE(de),
      .Move_Left(btn[0]), .Move_Up(btn[1]), .Move_Down(btn[2]), .Move_Right(btn[3]), .Select(btn[4]),
      .R(r), .G(g), .B(b), .cur_col(cur_col), .cur_row(cur_row), .sel_valid(sel_valid),
      .sel_col(sel_col), .sel_row(sel_row), .move_strobe(move_strobe)
   );
   function automatic logic [31:0] act(int k);
      case (k)
         0: return 32'(cur_col);
         1: return 32'(cur_row);
         2: return 32'(sel_valid);
         3: return 32'(sel_col);
         4: return 32'(sel_row);
         5: return 32'(move_strobe);
         6: return 32'({r, g, b});
         default: return 32'(n_strobe);
      endcase
   endfunction
   always @(negedge clk) begin
      if (move_strobe === 1'b1) n_strobe++;
      while (sb.size() > 0) begin
         exp_t e;
         logic [31:0] a;
         e = sb.pop_front();
         a = act(e.k);
         n_cmp++;
         if (a !== 32'(e.v)) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", e.nm, a, e.v);
         end
      end
   end
   task automatic chk(string nm, int k, int v);
      sb.push_back('{nm, k, v});
   endtask
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic press(int m);
      btn = btn & ~5'(m);
      tick(7);
      btn = '1;
      tick(8);
   endtask
   task automatic pix(int h, int v, logic d, int exp, string nm);
      hs = 10'(h);
      vs = 10'(v);
      de = d;
      tick();
      chk(nm, 6, exp);
   endtask
   initial begin
      tick(2);
      chk("rst_col", 0, 0); chk("rst_row", 1, 0); chk("rst_valid", 2, 0);
      chk("rst_strobe", 5, 0); chk("rst_rgb", 6, 0);
      rstn = 1'b1;
      tick(2);
      btn[3] = 1'b0;
      tick(6); chk("right_edge6", 0, 0);
      tick(1); chk("right_edge7", 0, 1);
      tick(3); chk("right_hold", 0, 1);
      btn[3] = 1'b1;
      tick(8); chk("right_release", 0, 1);
      press(1); chk("left_to0", 0, 0);
      press(1); chk("left_sat0", 0, 0);
      for (int i = 1; i <= 9; i++) begin
         press(8);
         chk("right_sat", 0, i > 7 ? 7 : i);
      end
      btn[2] = 1'b0; tick(3); btn[2] = 1'b1; tick(10);
      chk("glitch_row", 1, 0);
      press(9); chk("lr_cancel", 0, 7);
      press(5); chk("diag_col", 0, 6); chk("diag_row", 1, 1);
      repeat (5) press(1);
      chk("at_col1", 0, 1);
      press(16); chk("sel_valid", 2, 1); chk("sel_col", 3, 1); chk("sel_row", 4, 1); chk("sel_nostrobe", 5, 0);
      press(8); press(8); press(4);
      chk("to_col", 0, 3); chk("to_row", 1, 2);
      btn[4] = 1'b0;
      tick(6); chk("pre_strobe", 5, 0); chk("pre_valid", 2, 1);
      tick(1); chk("strobe", 5, 1); chk("strobe_valid", 2, 0); chk("strobe_fcol", 3, 1);
      chk("strobe_frow", 4, 1); chk("strobe_tcol", 0, 3); chk("strobe_trow", 1, 2);
      tick(1); chk("post_strobe", 5, 0); chk("post_scol", 3, 0); chk("post_srow", 4, 0); chk("post_valid", 2, 0);
      btn[4] = 1'b1; tick(8);
      press(1);
      press(16); chk("sel22_valid", 2, 1); chk("sel22_col", 3, 2); chk("sel22_row", 4, 2);
      press(16); chk("cancel_valid", 2, 0); chk("cancel_scol", 3, 0); chk("strobe_count", 7, 1);
      press(1); press(1); press(2); press(2);
      chk("home_col", 0, 0); chk("home_row", 1, 0);
      pix(43, 12, 1'b1, 16'hF81F, "px_corner");
      pix(70, 28, 1'b1, 16'h0000, "px_interior");
      pix(103, 12, 1'b1, 16'h0000, "px_cell1");
      press(16); chk("sel00_valid", 2, 1);
      pix(70, 28, 1'b1, 16'h07E0, "px_selfill");
      pix(45, 14, 1'b1, 16'h07E0, "px_inner_edge");
      pix(44, 13, 1'b1, 16'hF81F, "px_ring_in");
      pix(102, 45, 1'b1, 16'hF81F, "px_ring_far");
      pix(102, 46, 1'b1, 16'h0000, "px_row1");
      pix(70, 28, 1'b0, 16'h0000, "px_de0");
      pix(43, 12, 1'b1, 16'hF81F, "px_before_rst");
      @(negedge clk);
      @(posedge clk);
      #2 rstn = 1'b0;
      chk("async_rgb", 6, 0); chk("async_valid", 2, 0);
      tick(2);
      rstn = 1'b1;
      tick(2);
      @(negedge clk);
      @(negedge clk);
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
